counter_udmod: RTL and testbench

COUNTER_UDMOD -- requirements
Module: counter_udmod

---
 rtl/counter_udmod.sv | 90 +++++++++
 tb/tb_counter_udmod.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_udmod.sv
// Up/down modulo counter with runtime terminal value, load, clear, terminal-count
// pulse and sticky boundary flag. Define COUNTER_UDMOD_SAT_EN to add the sat port.
module counter_udmod #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             udbar,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             clr,
`ifdef COUNTER_UDMOD_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             sat_w;

`ifdef COUNTER_UDMOD_SAT_EN
    assign sat_w = sat;
`else
    assign sat_w = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = ZERO;
            ovf_d = 1'b0;
        end else if (ld) begin
            cnt_d = (ld_val > max_val) ? max_val : ld_val;
        end else if (en) begin
            if (udbar) begin
                // Counting up from at or above max_val (it may have been lowered) is a boundary.
                if (cnt_q < max_val) begin
                    cnt_d = cnt_q + ONE;
                end else begin
                    cnt_d = sat_w ? max_val : ZERO;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end
            end else begin
                if (cnt_q == ZERO) begin
                    cnt_d = sat_w ? ZERO : max_val;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end else if (cnt_q > max_val) begin
                    // Out of range after max_val dropped: snap into range, not a boundary.
                    cnt_d = max_val;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= ZERO;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt     = cnt_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign at_max  = (cnt_q == max_val);
    assign at_zero = (cnt_q == ZERO);

endmodule

// File: tb/tb_counter_udmod.sv
// Bench for counter_udmod: directed scenarios then random stimulus against an
// integer reference model of the counting rules.
module tb_counter_udmod;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0, udbar = 1'b1, ld = 1'b0, clr = 1'b0, sat = 1'b0;
    logic [W-1:0] ld_val = '0, max_val = '0;
    logic [W-1:0] cnt;
    logic         tc, ovf, at_max, at_zero;

    int vectors = 0;
    int errs    = 0;

    // reference state
    int m_cnt = 0;
    int m_tc  = 0;
    int m_ovf = 0;

    counter_udmod #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .udbar(udbar), .ld(ld),
        .ld_val(ld_val), .max_val(max_val), .clr(clr),
`ifdef COUNTER_UDMOD_SAT_EN
        .sat(sat),
`endif
        .cnt(cnt), .tc(tc), .ovf(ovf), .at_max(at_max), .at_zero(at_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge applied to the model using the inputs present at that edge.
    task automatic model_edge();
        int mx;
        int s;
        mx = int'(max_val);
`ifdef COUNTER_UDMOD_SAT_EN
        s = int'(sat);
`else
        s = 0;
`endif
        m_tc = 0;
        if (!rst) begin
            m_cnt = 0; m_ovf = 0;
        end else if (clr) begin
            m_cnt = 0; m_ovf = 0;
        end else if (ld) begin
            m_cnt = (int'(ld_val) < mx) ? int'(ld_val) : mx;
        end else if (en && udbar) begin
            if (m_cnt < mx) m_cnt = m_cnt + 1;
            else begin m_cnt = s ? mx : 0; m_tc = 1; m_ovf = 1; end
        end else if (en) begin
            if (m_cnt == 0) begin m_cnt = s ? 0 : mx; m_tc = 1; m_ovf = 1; end
            else if (m_cnt > mx) m_cnt = mx;
            else m_cnt = m_cnt - 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cnt"}, int'(cnt), m_cnt);
        chk({tag, ".tc"}, int'(tc), m_tc);
        chk({tag, ".ovf"}, int'(ovf), m_ovf);
        chk({tag, ".at_max"}, int'(at_max), int'(m_cnt == int'(max_val)));
        chk({tag, ".at_zero"}, int'(at_zero), int'(m_cnt == 0));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        en = 0; ld = 0; clr = 0;
    endtask

    int exp_up[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int exp_dn[4]  = '{1, 0, 9, 8};

    initial begin
        // reset state, with controls active to show they are ignored
        en = 1; ld = 1; ld_val = 4'd7; max_val = 4'd9;
        #2;
        check_all("reset_async");
        step("reset_held");
        @(negedge clk);
        rst = 1; idle();

        // wrap-up
        udbar = 1; en = 1;
        for (int i = 0; i < 12; i++) begin
            step("wrap_up");
            chk("wrap_up.const_cnt", int'(cnt), exp_up[i]);
            chk("wrap_up.const_tc", int'(tc), int'(i == 9));
            chk("wrap_up.const_ovf", int'(ovf), int'(i >= 9));
        end

        // wrap-down and direction change
        idle(); ld = 1; ld_val = 4'd2;
        step("dn_load");
        idle(); en = 1; udbar = 0;
        for (int i = 0; i < 4; i++) begin
            step("wrap_dn");
            chk("wrap_dn.const_cnt", int'(cnt), exp_dn[i]);
            chk("wrap_dn.const_tc", int'(tc), int'(i == 2));
        end
        udbar = 1;
        step("dir_change");
        chk("dir_change.const_cnt", int'(cnt), 9);

        // load clamp, ld beats en; then clr beats ld
        en = 1; ld = 1; ld_val = 4'd13;
        step("ld_clamp");
        chk("ld_clamp.const_cnt", int'(cnt), 9);
        chk("ld_clamp.const_tc", int'(tc), 0);
        clr = 1;
        step("clr_prio");
        chk("clr_prio.const_cnt", int'(cnt), 0);
        chk("clr_prio.const_ovf", int'(ovf), 0);

        // max_val lowered mid-count
        idle(); max_val = 4'd9; ld = 1; ld_val = 4'd8;
        step("mv_load_up");
        idle(); max_val = 4'd5; en = 1; udbar = 1;
        step("mv_up");
        chk("mv_up.const_cnt", int'(cnt), 0);
        chk("mv_up.const_tc", int'(tc), 1);
        idle(); max_val = 4'd9; ld = 1; ld_val = 4'd8;
        step("mv_load_dn");
        idle(); max_val = 4'd5; en = 1; udbar = 0;
        step("mv_dn");
        chk("mv_dn.const_cnt", int'(cnt), 5);
        chk("mv_dn.const_tc", int'(tc), 0);

        // max_val = 0: tc every enabled cycle
        idle(); max_val = 4'd0; en = 1;
        for (int i = 0; i < 3; i++) step("mv_zero");
        chk("mv_zero.const_tc", int'(tc), 1);

        // async reset between edges at cnt=5, ovf=1
        idle(); max_val = 4'd9; ld = 1; ld_val = 4'd5;
        step("ar_load");
        chk("ar_load.const_ovf", int'(ovf), 1);
        idle(); en = 1; clr = 1; ld = 1;
        rst = 0;
        #2;
        model_edge();
        check_all("ar_mid");
        step("ar_held");
        @(negedge clk);
        rst = 1; idle(); en = 1; udbar = 1;
        step("ar_resume");
        chk("ar_resume.const_cnt", int'(cnt), 1);

`ifdef COUNTER_UDMOD_SAT_EN
        // saturation
        idle(); max_val = 4'd9; ld = 1; ld_val = 4'd8;
        step("sat_load");
        idle(); en = 1; udbar = 1; sat = 1;
        for (int i = 0; i < 3; i++) begin
            step("sat_up");
            chk("sat_up.const_cnt", int'(cnt), 9);
            chk("sat_up.const_tc", int'(tc), int'(i > 0));
            chk("sat_up.const_ovf", int'(ovf), int'(i > 0));
        end
        udbar = 0; ld = 1; ld_val = 4'd0;
        step("sat_ld0");
        ld = 0;
        step("sat_dn");
        chk("sat_dn.const_cnt", int'(cnt), 0);
        sat = 0;
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            udbar = $urandom_range(0, 1);
            ld    = ($urandom_range(0, 15) == 0);
            clr   = ($urandom_range(0, 31) == 0);
            ld_val = W'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0: max_val = '0;
                    1: max_val = '1;
                    default: max_val = W'($urandom);
                endcase
            end
`ifdef COUNTER_UDMOD_SAT_EN
            sat = $urandom_range(0, 1);
`endif
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
